bid_cmd_sequencer: RTL and testbench
====================================

// Module: bid_cmd_sequencer
// PURPOSE
//  Upstream command feeder for the bids22 auction FSM. Buffers host commands (opcode+data, or round-start
//  entries) in a FIFO and replays them onto the auction's C_op/C_data/C_start inputs, pacing on cout.ready.
//  Checks cout.err after every issued op, logs errors and counts completed rounds.
// PARAMETERS
//  DATAWIDTH  32  width of cmd_data / c_data / round-length field
//  DEPTH      8   FIFO entries (power of 2, >=2)
//  OPW        4   opcode width (matches bids22defs opcode enum)
//  ERRW       4   auction error-code width (matches bids22defs error enum)
// PORTS
//  clk           in   1          clock, all logic on posedge
//  reset         in   1          synchronous, active-high reset
//  cmd_valid     in   1          host command valid
//  cmd_ready     out  1          FIFO can accept (level<DEPTH); transfer when valid&&ready
//  cmd_start     in   1          1: round-start entry, cmd_data = C_start hold length in cycles; 0: op entry
//  cmd_op        in   OPW        opcode for op entries (ignored for start entries)
//  cmd_data      in   DATAWIDTH  C_data payload or round length
//  c_op          out  OPW        to auction C_op
//  c_data        out  DATAWIDTH  to auction C_data
//  c_start       out  1          to auction C_start
//  auc_ready     in   1          from auction cout.ready
//  auc_err       in   ERRW       from auction cout.err (NOERROR = 0)
//  err_clr       in   1          clears err_sticky/err_code/err_count
//  busy          out  1          FSM not IDLE or FIFO non-empty
//  level         out  $clog2(DEPTH+1)  FIFO occupancy
//  err_sticky    out  1          an error has been captured since last clear
//  err_code      out  ERRW       first error captured since last clear
//  err_count     out  8          errors captured, saturates at 255
//  rounds_done   out  16         completed rounds, wraps at 2^16
// BEHAVIOUR
//  Reset: all outputs 0 (c_op=NO_OP, c_data=0, c_start=0, level=0, cmd_ready=1 after reset deasserts);
//   reset mid-round drops c_start at the next edge, FIFO emptied, counters cleared.
//  FIFO: no bypass; entry written at edge N is poppable at N+1. Push when full is dropped (cmd_ready=0).
//   Push+pop same cycle: level unchanged. Pointers wrap modulo DEPTH.
//  FSM IDLE -> ISSUE: when FIFO non-empty and auc_ready=1, pop head (registered outputs update next edge).
//  ISSUE (op entry): c_op/c_data driven exactly 1 cycle, then c_op=NO_OP, c_data holds -> CHECK.
//  CHECK: sample auc_err in this cycle (1 cycle after op seen); if !=0 capture -> IDLE. Issue rate <=1 op/2 cycles.
//  ISSUE (start entry): c_start=1 for L cycles (L=cmd_data; L=0 treated as 1), down-counter -> ROUND.
//  ROUND: c_start held; counter hits 0 -> c_start=0 -> DRAIN. auc_err not captured in ROUND (bid-level errors).
//  DRAIN: wait min 2 cycles (auction ROUNDOVER/READYNEXT) and then auc_ready=1 -> rounds_done++ -> IDLE.
//  auc_ready=0 in IDLE stalls pop indefinitely; no timeout.
//  Error capture: err_count sat-increments; err_code/err_sticky set only if err_sticky=0 (first wins).
//   err_clr with simultaneous capture: capture wins (sticky=1, code=new, count=1).
//  c_op/c_data/c_start are flop outputs; no combinational path from auc_* to c_*.
// CONFIGURATION
//  FLUSH_ON_ERR_EN defined: on any capture in CHECK, FIFO flushed (level=0 next edge), pushes that cycle dropped,
//   cmd_ready=0 for that cycle. Undefined: error only logged, remaining commands keep issuing.
// STRUCTURE
//  bids22defs adds: seq_state_t {IDLE,ISSUE,CHECK,ROUND,DRAIN}, cmd_entry_t packed {start,op,data},
//   reuses existing opcode and error enums.
//  Sub-module bid_cmd_fifo (DEPTH x cmd_entry_t, sync, flush input, level output); FSM+counters in top.
// TESTING
//  1 LOCK(data=0xA5) after reset, auc_ready=1 -> c_op=LOCK,c_data=0xA5 for 1 cycle, then NO_OP; err_count=0.
//  2 start entry L=4 -> c_start high exactly 4 cycles; hold ready=0 1 cycle after -> rounds_done=1 after ready=1.
//  3 start entry L=0 -> c_start high 1 cycle; rounds_done increments.
//  4 push 9 entries back-to-back with auc_ready=0, DEPTH=8 -> 9th dropped, cmd_ready=0, level=8; nothing issued.
//  5 op with auc_err=BADKEY in CHECK then op with INVALID_OP -> err_code=BADKEY, err_count=2; err_clr -> all 0.
//  6 FLUSH_ON_ERR_EN, 3 queued ops, first errors -> level=0, remaining 2 never on c_op; reset mid-ROUND -> c_start=0.

Source files
------------

// File: rtl/bid_cmd_sequencer_pkg.sv
// Shared types for the bids22 command sequencer: opcode/error enums, FSM states,
// the FIFO entry layout and a saturating counter helper.
package bid_cmd_sequencer_pkg;

   localparam int DATAWIDTH_D = 32;
   localparam int OPW_D       = 4;
   localparam int ERRW_D      = 4;

   typedef enum logic [OPW_D-1:0] {
      NO_OP       = 4'd0,
      LOCK        = 4'd1,
      UNLOCK      = 4'd2,
      SET_KEY     = 4'd3,
      SET_RESERVE = 4'd4,
      ADD_BIDDER  = 4'd5,
      BID         = 4'd6,
      CLOSE       = 4'd7
   } opcode_t;

   typedef enum logic [ERRW_D-1:0] {
      NOERROR        = 4'd0,
      BADKEY         = 4'd1,
      ALREADY_LOCKED = 4'd2,
      INVALID_OP     = 4'd3,
      NOT_LOCKED     = 4'd4,
      OUT_OF_BIDDERS = 4'd5
   } error_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      CHECK = 3'd2,
      ROUND = 3'd3,
      DRAIN = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic                   start;
      logic [OPW_D-1:0]       op;
      logic [DATAWIDTH_D-1:0] data;
   } cmd_entry_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/bid_cmd_sequencer_if.sv
// Host command channel and auction drive channel of the bids22 command sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready; the host holds
// its fields stable while cmd_valid is high, and cmd_ready never depends on cmd_valid.
interface bid_cmd_if #(
   parameter int DATAWIDTH = 32,
   parameter int OPW       = 4
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_start;
   logic [OPW-1:0]       cmd_op;
   logic [DATAWIDTH-1:0] cmd_data;

   modport master (output cmd_valid, cmd_start, cmd_op, cmd_data, input cmd_ready);
   modport slave  (input cmd_valid, cmd_start, cmd_op, cmd_data, output cmd_ready);
endinterface

interface bid_auc_if #(
   parameter int DATAWIDTH = 32,
   parameter int OPW       = 4,
   parameter int ERRW      = 4
);
   logic [OPW-1:0]       c_op;
   logic [DATAWIDTH-1:0] c_data;
   logic                 c_start;
   logic                 auc_ready;
   logic [ERRW-1:0]      auc_err;

   modport master (output c_op, c_data, c_start, input auc_ready, auc_err);
   modport slave  (input c_op, c_data, c_start, output auc_ready, auc_err);
endinterface

// File: rtl/bid_cmd_sequencer_fifo.sv
// Synchronous command FIFO (no bypass) with flush; a full FIFO drops pushes even when popping.
module bid_cmd_fifo
   import bid_cmd_sequencer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  cmd_entry_t                   din,
   input  logic                         pop,
   output cmd_entry_t                   dout,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   cmd_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign dout    = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk) begin
      if (do_push && !reset) mem[wr_ptr] <= din;
   end

   // Pointers rely on DEPTH being a power of two so they wrap for free.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/bid_cmd_sequencer.sv
// Replays buffered host commands onto the bids22 auction inputs, checks errors, counts rounds.
// Optional FLUSH_ON_ERR_EN: an error captured in CHECK flushes the FIFO and blocks that cycle's push.
module bid_cmd_sequencer
   import bid_cmd_sequencer_pkg::*;
#(
   parameter int DATAWIDTH = 32,
   parameter int DEPTH     = 8,
   parameter int OPW       = 4,
   parameter int ERRW      = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   bid_cmd_if.slave                     cmd,
   bid_auc_if.master                    auc,
   input  logic                         err_clr,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         err_sticky,
   output logic [ERRW-1:0]              err_code,
   output logic [7:0]                   err_count,
   output logic [15:0]                  rounds_done,
   output seq_state_t                   dbg_state
);
   seq_state_t           state;
   cmd_entry_t           push_entry;
   cmd_entry_t           head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;
   logic                 flush;
   logic                 capture;
   logic [DATAWIDTH-1:0] hold_cnt;
   logic                 drain_wait;
   logic [OPW-1:0]       c_op_q;
   logic [DATAWIDTH-1:0] c_data_q;
   logic                 c_start_q;

   assign capture = (state == CHECK) && (auc.auc_err != '0);
`ifdef FLUSH_ON_ERR_EN
   assign flush = capture;
`else
   assign flush = 1'b0;
`endif

   assign cmd.cmd_ready = !fifo_full && !flush;
   assign push          = cmd.cmd_valid && cmd.cmd_ready;
   assign pop           = (state == IDLE) && !fifo_empty && auc.auc_ready;
   assign busy          = (state != IDLE) || !fifo_empty;
   assign dbg_state     = state;
   assign push_entry    = '{start: cmd.cmd_start, op: cmd.cmd_op, data: cmd.cmd_data};
   assign auc.c_op      = c_op_q;
   assign auc.c_data    = c_data_q;
   assign auc.c_start   = c_start_q;

   bid_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .din   (push_entry),
      .pop   (pop),
      .dout  (head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // c_start_q doubles as the "this is a round" marker while in ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         c_op_q      <= NO_OP;
         c_data_q    <= '0;
         c_start_q   <= 1'b0;
         hold_cnt    <= '0;
         drain_wait  <= 1'b0;
         rounds_done <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  c_data_q <= head.data;
                  if (head.start) begin
                     c_start_q <= 1'b1;
                     hold_cnt  <= (head.data == '0) ? '0 : head.data - DATAWIDTH'(1);
                  end else begin
                     c_op_q <= head.op;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE, ROUND: begin
               if (!c_start_q) begin
                  c_op_q <= NO_OP;
                  state  <= CHECK;
               end else if (hold_cnt == '0) begin
                  c_start_q  <= 1'b0;
                  drain_wait <= 1'b0;
                  state      <= DRAIN;
               end else begin
                  hold_cnt <= hold_cnt - DATAWIDTH'(1);
                  state    <= ROUND;
               end
            end
            CHECK: state <= IDLE;
            DRAIN: begin
               // Two DRAIN cycles cover the auction's ROUNDOVER/READYNEXT before ready counts.
               if (!drain_wait) begin
                  drain_wait <= 1'b1;
               end else if (auc.auc_ready) begin
                  rounds_done <= rounds_done + 16'd1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_sticky <= 1'b0;
         err_code   <= '0;
         err_count  <= '0;
      end else if (capture) begin
         if (err_clr || !err_sticky) begin
            err_sticky <= 1'b1;
            err_code   <= auc.auc_err;
         end
         err_count <= err_clr ? 8'd1 : sat_inc8(err_count);
      end else if (err_clr) begin
         err_sticky <= 1'b0;
         err_code   <= '0;
         err_count  <= '0;
      end
   end

endmodule

// File: tb/tb_bid_cmd_sequencer.sv
// Bench for bid_cmd_sequencer: timestamp-based model of issue/round timing plus directed literal checks.
module tb_bid_cmd_sequencer;
   import bid_cmd_sequencer_pkg::*;

   localparam int DW    = 32;
   localparam int OPW   = 4;
   localparam int ERRW  = 4;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH+1);
   localparam int EW    = 1 + OPW + DW;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            err_clr = 1'b0;
   logic            busy;
   logic [LW-1:0]   level;
   logic            err_sticky;
   logic [ERRW-1:0] err_code;
   logic [7:0]      err_count;
   logic [15:0]     rounds_done;
   seq_state_t      dbg_state;

   bid_cmd_if #(.DATAWIDTH(DW), .OPW(OPW)) cmd_bus();
   bid_auc_if #(.DATAWIDTH(DW), .OPW(OPW), .ERRW(ERRW)) auc_bus();

   bid_cmd_sequencer #(.DATAWIDTH(DW), .DEPTH(DEPTH), .OPW(OPW), .ERRW(ERRW)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cmd_bus),
      .auc         (auc_bus),
      .err_clr     (err_clr),
      .busy        (busy),
      .level       (level),
      .err_sticky  (err_sticky),
      .err_code    (err_code),
      .err_count   (err_count),
      .rounds_done (rounds_done),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard / model ----------------
   // Expected FIFO content plus timestamps (edge numbers) of the last op issue and round start.
   typedef enum {M_FREE, M_OP, M_ROUND} mmode_t;
   logic [EW-1:0]   exp_q[$];
   mmode_t          m_mode = M_FREE;
   longint          e = 0, m_pop_e = -10, m_free_e = 0, m_op_e = -10, m_rs_e = -1000, m_len = 0;
   logic [OPW-1:0]  m_op = '0;
   logic [DW-1:0]   m_data = '0;
   logic            m_sticky = 1'b0;
   logic [ERRW-1:0] m_code = '0;
   int              m_count = 0;
   int              m_rounds = 0;
   bit              m_live = 1'b0;
   bit              m_fl, m_full_pre, m_cap;
   logic [EW-1:0]   m_ent;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_mode = M_FREE; e = 0; m_free_e = 0; m_pop_e = -10; m_op_e = -10;
         m_rs_e = -1000; m_len = 0; m_op = '0; m_data = '0;
         m_sticky = 1'b0; m_code = '0; m_count = 0; m_rounds = 0; m_live = 1'b1;
      end else begin
         e++;
         m_fl  = 1'b0;
         m_cap = (m_mode == M_OP) && (e == m_pop_e + 2) && (auc_bus.auc_err != '0);
         if (m_cap) begin
            if (err_clr || !m_sticky) begin m_sticky = 1'b1; m_code = auc_bus.auc_err; end
            m_count = err_clr ? 1 : ((m_count == 255) ? 255 : m_count + 1);
`ifdef FLUSH_ON_ERR_EN
            m_fl = 1'b1;
`endif
         end else if (err_clr) begin
            m_sticky = 1'b0; m_code = '0; m_count = 0;
         end
         if (m_mode == M_OP && e == m_pop_e + 2) begin m_mode = M_FREE; m_free_e = e + 1; end
         if (m_mode == M_ROUND && e >= m_pop_e + m_len + 2 && auc_bus.auc_ready) begin
            m_rounds = (m_rounds + 1) % 65536; m_mode = M_FREE; m_free_e = e + 1;
         end
         m_full_pre = (exp_q.size() >= DEPTH);
         if (m_mode == M_FREE && e >= m_free_e && exp_q.size() > 0 && auc_bus.auc_ready) begin
            m_ent   = exp_q.pop_front();
            m_pop_e = e;
            m_data  = m_ent[DW-1:0];
            if (m_ent[EW-1]) begin
               m_mode = M_ROUND; m_rs_e = e;
               m_len  = (m_ent[DW-1:0] == '0) ? 1 : longint'(m_ent[DW-1:0]);
            end else begin
               m_mode = M_OP; m_op = m_ent[DW+OPW-1:DW]; m_op_e = e;
            end
         end
         if (m_fl) exp_q.delete();
         else if (cmd_bus.cmd_valid && !m_full_pre)
            exp_q.push_back({cmd_bus.cmd_start, cmd_bus.cmd_op, cmd_bus.cmd_data});
      end
   end

   // Compare process: one sample per cycle, 1 time unit after the falling edge.
   initial forever begin
      bit exp_ready;
      @(negedge clk);
      #1;
      if (m_live) begin
         exp_ready = (exp_q.size() < DEPTH);
`ifdef FLUSH_ON_ERR_EN
         if (m_mode == M_OP && e + 1 == m_pop_e + 2 && auc_bus.auc_err != '0) exp_ready = 1'b0;
`endif
         check("c_op", auc_bus.c_op, (m_op_e == e) ? m_op : '0);
         check("c_data", auc_bus.c_data, m_data);
         check("c_start", auc_bus.c_start, (e >= m_rs_e) && (e < m_rs_e + m_len));
         check("level", level, exp_q.size());
         check("cmd_ready", cmd_bus.cmd_ready, exp_ready);
         check("busy", busy, (m_mode != M_FREE) || (exp_q.size() != 0));
         check("err_sticky", err_sticky, m_sticky);
         check("err_code", err_code, m_code);
         check("err_count", err_count, m_count);
         check("rounds_done", rounds_done, m_rounds);
      end
   end

   // ---------------- auction error responder ----------------
   logic [ERRW-1:0] err_map [16];
   logic [OPW-1:0]  prev_op = '0;

   initial begin
      auc_bus.auc_err = '0;
      forever begin
         @(negedge clk);
         auc_bus.auc_err = err_map[prev_op];
         prev_op = auc_bus.c_op;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_one(input bit st, input logic [OPW-1:0] op, input logic [DW-1:0] d);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_start = st;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_data  = d;
      @(negedge clk);
      cmd_bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(name, busy, 1'b0);
   endtask

   task automatic count_start_high(input string name, input int want);
      int cnt;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (auc_bus.c_start) cnt++;
         else if (cnt > 0) break;
      end
      check(name, cnt, want);
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int cnt;
      logic [DW-1:0] dseen;
      for (int i = 0; i < 16; i++) err_map[i] = '0;
      cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_start = 1'b0;
      cmd_bus.cmd_op = '0; cmd_bus.cmd_data = '0;
      auc_bus.auc_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #2;
      check("rst_level", level, 0);
      check("rst_c_op", auc_bus.c_op, NO_OP);
      check("rst_c_start", auc_bus.c_start, 0);
      check("rst_cmd_ready", cmd_bus.cmd_ready, 1);
      check("rst_state", dbg_state, IDLE);
      @(negedge clk);
      auc_bus.auc_ready = 1'b1;

      // 1: single LOCK op
      push_one(1'b0, LOCK, 32'hA5);
      cnt = 0; dseen = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (auc_bus.c_op == LOCK) begin cnt++; dseen = auc_bus.c_data; end
      end
      check("t1_lock_cycles", cnt, 1);
      check("t1_lock_data", dseen, 32'hA5);
      check("t1_err_count", err_count, 0);
      check("t1_c_op_idle", auc_bus.c_op, NO_OP);

      // 2: round of length 4, auction not ready for one drain cycle
      push_one(1'b1, NO_OP, 32'd4);
      count_start_high("t2_start_len", 4);
      auc_bus.auc_ready = 1'b0;
      @(negedge clk);
      auc_bus.auc_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("t2_rounds", rounds_done, 1);

      // 3: zero-length round behaves as length 1
      push_one(1'b1, NO_OP, 32'd0);
      count_start_high("t3_start_len", 1);
      repeat (4) @(negedge clk);
      check("t3_rounds", rounds_done, 2);

      // 4: overfill while auction stalls
      auc_bus.auc_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_start = 1'b0;
         cmd_bus.cmd_op = UNLOCK; cmd_bus.cmd_data = 32'h100 + i;
         if (i == 8) check("t4_ready_full", cmd_bus.cmd_ready, 0);
         @(negedge clk);
      end
      cmd_bus.cmd_valid = 1'b0;
      check("t4_level", level, 8);
      check("t4_no_issue", auc_bus.c_op, NO_OP);
      auc_bus.auc_ready = 1'b1;
      wait_idle("t4_drain_idle", 200);

      // 5: two erroring ops, first code wins, then clear
      err_map[SET_KEY] = BADKEY;
      err_map[BID]     = INVALID_OP;
      push_one(1'b0, SET_KEY, 32'd1);
      push_one(1'b0, BID, 32'd2);
      wait_idle("t5_idle", 40);
      check("t5_code", err_code, BADKEY);
      check("t5_sticky", err_sticky, 1);
`ifdef FLUSH_ON_ERR_EN
      check("t5_count", err_count, 1);
`else
      check("t5_count", err_count, 2);
`endif
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #2;
      check("t5_clr_sticky", err_sticky, 0);
      check("t5_clr_count", err_count, 0);

      // 5b: clear held through a capture, capture wins
      err_clr = 1'b1;
      push_one(1'b0, SET_KEY, 32'd3);
      wait_idle("t5b_idle", 20);
      err_clr = 1'b0;
      #2;
      check("t5b_sticky", err_sticky, 1);
      check("t5b_code", err_code, BADKEY);
      check("t5b_count", err_count, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      err_map[SET_KEY] = NOERROR;
      err_map[BID]     = NOERROR;

      // 6: three queued ops, the first errors
      err_map[ADD_BIDDER] = ALREADY_LOCKED;
      auc_bus.auc_ready = 1'b0;
      push_one(1'b0, ADD_BIDDER, 32'd7);
      push_one(1'b0, SET_RESERVE, 32'd8);
      push_one(1'b0, CLOSE, 32'd9);
      auc_bus.auc_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (auc_bus.c_op == SET_RESERVE) cnt++;
         if (!busy) break;
      end
      check("t6_idle", busy, 0);
      check("t6_err_count", err_count, 1);
      check("t6_level", level, 0);
`ifdef FLUSH_ON_ERR_EN
      check("t6_flushed_op", cnt, 0);
`else
      check("t6_issued_op", cnt, 1);
`endif
      err_map[ADD_BIDDER] = NOERROR;

      // reset in the middle of a long round
      push_one(1'b1, NO_OP, 32'd20);
      for (int i = 0; i < 10; i++) begin
         if (auc_bus.c_start) break;
         @(negedge clk);
      end
      check("t6_round_started", auc_bus.c_start, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("t6_rst_c_start", auc_bus.c_start, 0);
      check("t6_rst_rounds", rounds_done, 0);
      check("t6_rst_level", level, 0);
      check("t6_rst_busy", busy, 0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
